// File: rtl/phase_duty_meter_pkg.sv
// Shared types for the phase/duty meter: FSM state encoding.
package phase_duty_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/phase_duty_meter_if.sv
// Result bundle of the phase/duty meter with its valid/ready handshake.
interface phase_duty_meter_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W-1:0] shift_cnt;
    logic             shift_vld;
    logic             ovf;
    logic             meas_valid;
    logic             meas_ready;

    modport master (
        output high_cnt, low_cnt, shift_cnt,
        output shift_vld, ovf, meas_valid,
        input  meas_ready
    );

    modport slave (
        input  high_cnt, low_cnt, shift_cnt,
        input  shift_vld, ovf, meas_valid,
        output meas_ready
    );
endinterface

// File: rtl/sync_edge_det.sv
// Optional 2-flop synchronizer followed by a 1-flop edge detector.
module sync_edge_det #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev;

    generate
        if (SYNC_EN) begin : g_sync
            logic s1;
            logic s2;
            always_ff @(posedge clk) begin
                s1 <= din;
                s2 <= s1;
            end
            assign level = s2;
        end else begin : g_bypass
            assign level = din;
        end
    endgenerate

    // History always tracks the level, so reset never creates a false edge.
    always_ff @(posedge clk) begin
        prev <= level;
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/phase_duty_meter.sv
// Measures high/low time of sig_a and the sig_a->sig_b rise delay, one period
// per measurement, results delivered over a valid/ready handshake.
import phase_duty_meter_pkg::*;

module phase_duty_meter #(
    parameter int CNT_W   = 16,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sig_a,
    input  logic sig_b,
    phase_duty_meter_if.master res
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic a_lvl, a_rise, a_fall;
    logic b_lvl, b_rise, b_fall;

    state_t state, nxt;

    logic [CNT_W-1:0] hi_q, hi_n;
    logic [CNT_W-1:0] lo_q, lo_n;
    logic [CNT_W-1:0] sh_q, sh_n;
    logic             vld_q, vld_n;
    logic             arm_q, arm_n;
    logic             sat;
    logic             load;

    logic [CNT_W-1:0] high_r, low_r, shift_r;
    logic             svld_r, ovf_r;

    logic unused_ok;
    assign unused_ok = ^{a_lvl, b_lvl, b_fall};

    sync_edge_det #(.SYNC_EN(SYNC_EN)) u_det_a (
        .clk   (clk),
        .din   (sig_a),
        .level (a_lvl),
        .rise  (a_rise),
        .fall  (a_fall)
    );

    sync_edge_det #(.SYNC_EN(SYNC_EN)) u_det_b (
        .clk   (clk),
        .din   (sig_b),
        .level (b_lvl),
        .rise  (b_rise),
        .fall  (b_fall)
    );

    assign load = (state != HOLD) && (nxt == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_q    <= '0;
            vld_q   <= 1'b0;
            arm_q   <= 1'b0;
            high_r  <= '0;
            low_r   <= '0;
            shift_r <= '0;
            svld_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state <= nxt;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            sh_q  <= sh_n;
            vld_q <= vld_n;
            arm_q <= arm_n;
            if (load) begin
                high_r  <= hi_n;
                low_r   <= lo_n;
                shift_r <= (vld_n | sat) ? sh_n : '0;
                svld_r  <= vld_n;
                ovf_r   <= sat;
            end
        end
    end

    always_comb begin
        nxt   = state;
        hi_n  = hi_q;
        lo_n  = lo_q;
        sh_n  = sh_q;
        vld_n = vld_q;
        arm_n = arm_q;
        sat   = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && a_rise) begin
                    nxt   = HIGH;
                    hi_n  = {{(CNT_W-1){1'b0}}, 1'b1};
                    lo_n  = '0;
                    sh_n  = '0;
                    vld_n = b_rise;
                    arm_n = ~b_rise;
                end
            end
            HIGH, LOW: begin
                if (state == LOW && a_rise) begin
                    // Closing edge: b_rise here belongs to the next period.
                    nxt = HOLD;
                end else begin
                    if (state == HIGH && a_fall) begin
                        nxt  = LOW;
                        lo_n = {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (state == HIGH) begin
                        hi_n = hi_q + 1'b1;
                    end else begin
                        lo_n = lo_q + 1'b1;
                    end
                    if (arm_q) begin
                        sh_n = sh_q + 1'b1;
                        if (b_rise) begin
                            vld_n = 1'b1;
                            arm_n = 1'b0;
                        end
                    end
                    sat = (hi_n == MAX) || (lo_n == MAX) || (sh_n == MAX);
                    if (sat) begin
                        nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (res.meas_ready) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        res.meas_valid = (state == HOLD);
        res.high_cnt   = high_r;
        res.low_cnt    = low_r;
        res.shift_cnt  = shift_r;
        res.shift_vld  = svld_r;
        res.ovf        = ovf_r;
    end

endmodule

// File: tb/tb_phase_duty_meter.sv
// Directed bench for phase_duty_meter: generated sig_a/sig_b waveforms with
// hand-computed period, duty and shift values.
`timescale 1ns/1ps

module tb_phase_duty_meter;

    logic clk = 1'b0;
    logic rst, en, sig_a, sig_b, ready;

    always #0.5 clk = ~clk;

    phase_duty_meter_if #(.CNT_W(16)) r1 ();
    phase_duty_meter_if #(.CNT_W(4))  r2 ();

    assign r1.meas_ready = ready;
    assign r2.meas_ready = ready;

    phase_duty_meter #(.CNT_W(16), .SYNC_EN(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .sig_a (sig_a),
        .sig_b (sig_b),
        .res   (r1)
    );

    phase_duty_meter #(.CNT_W(4), .SYNC_EN(1'b1)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .sig_a (sig_a),
        .sig_b (sig_b),
        .res   (r2)
    );

    int nchk = 0;
    int nerr = 0;

    int ph, per, hi_t, dly;
    bit gen_on, b_zero;
    logic [15:0] ahist;

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (gen_on) begin
            ph    = (ph + 1 >= per) ? 0 : ph + 1;
            sig_a = (ph < hi_t);
        end else begin
            sig_a = 1'b0;
        end
        ahist = {ahist[14:0], sig_a};
        sig_b = b_zero ? 1'b0 : ahist[dly];
    endtask

    task automatic start(input int h, input int p, input int d,
                         input bit bz);
        gen_on = 1'b0;
        hi_t   = h;
        per    = p;
        dly    = d;
        b_zero = bz;
        rst    = 1'b1;
        repeat (3) tick();
        rst    = 1'b0;
        ph     = p - 1;
        gen_on = 1'b1;
    endtask

    task automatic wait_valid(input bit which);
        int n = 0;
        while (((which ? r2.meas_valid : r1.meas_valid) !== 1'b1)
               && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("timeout", 0, 1);
    endtask

    task automatic expect_res(input string tag, input int h, input int l,
                              input int s, input bit v, input bit o);
        check({tag, "_valid"}, r1.meas_valid, 1);
        check({tag, "_high"},  r1.high_cnt,   h);
        check({tag, "_low"},   r1.low_cnt,    l);
        check({tag, "_shift"}, r1.shift_cnt,  s);
        check({tag, "_svld"},  r1.shift_vld,  v);
        check({tag, "_ovf"},   r1.ovf,        o);
    endtask

    task automatic expect_zero(input string tag);
        check({tag, "_valid"}, r1.meas_valid, 0);
        check({tag, "_high"},  r1.high_cnt,   0);
        check({tag, "_low"},   r1.low_cnt,    0);
        check({tag, "_shift"}, r1.shift_cnt,  0);
        check({tag, "_svld"},  r1.shift_vld,  0);
        check({tag, "_ovf"},   r1.ovf,        0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int stable;
        int vcnt;
        rst = 1'b1; en = 1'b0; ready = 1'b1;
        sig_a = 1'b0; sig_b = 1'b0;
        gen_on = 1'b0; b_zero = 1'b0; ahist = '0;
        ph = 0; per = 10; hi_t = 5; dly = 0;

        // 1: 5/5 with 2-cycle delayed sig_b
        en = 1'b1;
        start(5, 10, 2, 1'b0);
        expect_zero("rst");
        for (int i = 0; i < 2; i++) begin
            wait_valid(1'b0);
            expect_res("t1", 5, 5, 2, 1'b1, 1'b0);
            tick();
            check("t1_pulse", r1.meas_valid, 0);
        end

        // 2: 3/7, sig_b identical to sig_a
        start(3, 10, 0, 1'b0);
        wait_valid(1'b0);
        expect_res("t2", 3, 7, 0, 1'b1, 1'b0);

        // 3: sig_b never rises
        start(5, 10, 0, 1'b1);
        wait_valid(1'b0);
        expect_res("t3", 5, 5, 0, 1'b0, 1'b0);

        // 4: consumer stalls for 30 cycles
        start(5, 10, 2, 1'b0);
        ready = 1'b0;
        wait_valid(1'b0);
        expect_res("t4", 5, 5, 2, 1'b1, 1'b0);
        stable = 0;
        repeat (30) begin
            tick();
            if (r1.meas_valid === 1'b1 && r1.high_cnt == 16'd5 &&
                r1.low_cnt == 16'd5 && r1.shift_cnt == 16'd2 &&
                r1.shift_vld === 1'b1)
                stable++;
        end
        check("t4_stable", stable, 30);
        ready = 1'b1;
        tick();
        check("t4_one_hs", r1.meas_valid, 0);
        wait_valid(1'b0);
        expect_res("t4b", 5, 5, 2, 1'b1, 1'b0);

        // 5: 4-bit counters saturate on a 20-cycle high phase
        start(20, 40, 2, 1'b0);
        wait_valid(1'b1);
        check("t5_valid", r2.meas_valid, 1);
        check("t5_ovf",   r2.ovf,        1);
        check("t5_high",  r2.high_cnt,   15);
        check("t5_low",   r2.low_cnt,    0);
        check("t5_shift", r2.shift_cnt,  2);
        wait_valid(1'b0);
        expect_res("t5w", 20, 20, 2, 1'b1, 1'b0);

        // 6: reset while in LOW, then en gating
        start(5, 10, 2, 1'b0);
        wait_valid(1'b0);
        expect_res("t6a", 5, 5, 2, 1'b1, 1'b0);
        repeat (16) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_zero("t6_rst");
        wait_valid(1'b0);
        expect_res("t6b", 5, 5, 2, 1'b1, 1'b0);
        en = 1'b0;
        tick();
        vcnt = 0;
        repeat (40) begin
            tick();
            if (r1.meas_valid !== 1'b0) vcnt++;
        end
        check("t6_en_off", vcnt, 0);
        en = 1'b1;
        wait_valid(1'b0);
        expect_res("t6c", 5, 5, 2, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
